// File: rtl/shift_unit.sv
`default_nettype none
// ============================================================================
// Module   : shift_unit
// Purpose  : Multicycle 64-bit shifter for SLL/SRL/SRA and the W-variants.
//            It moves up to STEP bits per cycle under a start/done handshake.
//            The registered result is held until the next completion.
// Revision : 1.0  initial release
// ============================================================================
module shift_unit #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        word,
    input  logic [5:0]  shamt,
    input  logic [63:0] data_in,
    output logic [63:0] out_shift,
    output logic        busy,
    output logic        done
);

    localparam logic [5:0] c_step   = 6'(STEP);
    localparam logic [1:0] c_op_sll = 2'b00;
    localparam logic [1:0] c_op_srl = 2'b01;
    localparam logic [1:0] c_op_sra = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_work;
    logic [63:0] w_work_nxt;
    logic [5:0]  r_cnt;
    logic [5:0]  w_cnt_nxt;
    logic [1:0]  r_op;
    logic [1:0]  w_op_nxt;
    logic        r_word;
    logic        w_word_nxt;
    logic [5:0]  w_n;
    logic [5:0]  w_k;
    logic [63:0] w_load;
    logic [63:0] w_stepped;
    logic [63:0] w_result;
    logic        w_finish;

    // Operand preparation at load: effective amount and pre-extended word operand
    always_comb begin
        w_n    = word ? {1'b0, shamt[4:0]} : shamt;
        w_load = data_in;
        if (word && (op == c_op_srl)) begin
            w_load = {32'b0, data_in[31:0]};
        end else if (word && (op == c_op_sra)) begin
            w_load = {{32{data_in[31]}}, data_in[31:0]};
        end
    end

    // One iteration of the shift: at most STEP bits, never past the remaining count
    always_comb begin
        w_k = (r_cnt < c_step) ? r_cnt : c_step;
        case (r_op)
            c_op_sll: w_stepped = r_work << w_k;
            c_op_srl: w_stepped = r_work >> w_k;
            c_op_sra: w_stepped = $signed(r_work) >>> w_k;
            default:  w_stepped = r_work;
        endcase
    end

    // Next-state logic for the control FSM and the working datapath
    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_word_nxt  = r_word;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_work_nxt  = w_load;
                    w_cnt_nxt   = (op == 2'b11) ? 6'd0 : w_n;
                    w_op_nxt    = op;
                    w_word_nxt  = word;
                    w_state_nxt = (w_cnt_nxt == 6'd0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_work_nxt = w_stepped;
                w_cnt_nxt  = r_cnt - w_k;
                if (w_cnt_nxt == 6'd0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Result formatting on the edge that enters DONE (W-results sign-extend bit 31)
    always_comb begin
        w_finish = (w_state_nxt == S_DONE) && (r_state != S_DONE);
        w_result = w_word_nxt ? {{32{w_work_nxt[31]}}, w_work_nxt[31:0]} : w_work_nxt;
    end

    // State, working register and result register; reset discards any partial work
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_work    <= 64'd0;
            r_cnt     <= 6'd0;
            r_op      <= 2'b00;
            r_word    <= 1'b0;
            out_shift <= 64'd0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_word  <= w_word_nxt;
            if (w_finish) begin
                out_shift <= w_result;
            end
        end
    end

    assign done = (r_state == S_DONE);
    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire
